div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//  EXU-side requester for the iterative divider (divisioner). Accepts one decoded
//  DIV/DIVU/REM/REMU(W) op from the pipeline and drives the divider valid/ready
//  handshake. Holds operands and mode stable for the whole run and captures the
//  single-cycle result. Applies RV64 result fix-ups, then holds the result until
//  writeback takes it.
// PARAMETERS
//  XLEN      64  operand/result width (only 64 supported)
//  TIMEOUT   80  max cycles in WAIT before timeout_err (>= 66)
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous reset, active low
//  in_valid       in   1     decoded div op valid
//  in_ready       out  1     controller idle, can accept op
//  in_op          in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  in_word        in   1     1 = *W variant (32-bit)
//  in_src1        in   64    dividend (rs1)
//  in_src2        in   64    divisor (rs2)
//  flush          in   1     pipeline kill; cancels op in flight
//  res_valid      out  1     result valid (held until res_ready)
//  res_ready      in   1     writeback accepts result
//  res_data       out  64    final rd value
//  div_valid      out  1     request to divider
//  div_ready      in   1     divider idle
//  div_flush      out  1     cancel divider run (one-cycle pulse)
//  div_divw       out  1     to divider divw (held through run)
//  div_signed     out  1     to divider div_signed (held through run)
//  div_dividend   out  64    to divider dividend
//  div_divisor    out  64    to divider divisor
//  div_out_valid  in   1     divider result valid (single cycle)
//  div_quotient   in   64    divider quotient
//  div_remainder  in   64    divider remainder
//  busy           out  1     state != IDLE (stall source)
//  timeout_err    out  1     sticky; set when WAIT exceeds TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; res_valid, div_valid, div_flush, timeout_err, busy = 0;
//    res_data and div_* data = 0. in_ready = (state==IDLE).
//  Accept: in_valid & in_ready & !flush. Register op, word, src1, src2, then go
//    to REQ (or DONE on bypass). div_signed = ~in_op[0]; div_divw = in_word.
//  States:
//   IDLE -> REQ on accept.
//   REQ: div_valid=1. On div_ready -> WAIT; div_valid drops the next cycle.
//   WAIT: cycle counter runs. On div_out_valid, capture the result -> DONE.
//   DONE: res_valid=1. On res_ready -> IDLE.
//  Result select: REM ops use div_remainder, else div_quotient. in_word: res_data
//    = sign-extend of bit 31 of the selected 32-bit value (divider zero-extends).
//  Latency: accept at T; div_valid from T+1. Divider handshake at T+1 when idle.
//    res_valid at T+1+N+1 (N = 32 word / 64 dword divider cycles).
//  Flush:
//   REQ: drop div_valid the next cycle, no div_flush, -> IDLE.
//   WAIT: pulse div_flush one cycle, -> IDLE, discard any result.
//   DONE: drop res_valid, -> IDLE.
//   flush with div_out_valid in the same cycle: flush wins, result discarded.
//   flush in the same cycle as in_valid in IDLE: op not accepted.
//  Timeout: counter resets on entering WAIT. At TIMEOUT set timeout_err (sticky
//    until reset), pulse div_flush, -> IDLE, no res_valid.
//  Async rst_n mid-op: immediate return to IDLE with all outputs at reset values.
// CONFIGURATION
//  DIV_BYPASS_EN defined: special cases skip the divider and go IDLE->DONE, with
//    res_valid at T+1. Operand width is 32 bits if in_word, else 64.
//   divisor==0: quotient = all ones; remainder = dividend.
//   signed, dividend==MIN and divisor==-1: quotient = dividend; remainder = 0.
//   Word results are sign-extended as above.
//  Not defined: all ops go through the divider. res_data is the divider output
//    after the width fix-up only.
// TESTING
//  DIVU 100/7, dword -> div_valid 1 cycle after handshake; res_data=14 ~66 cycles later.
//  REMW src1=0xFFFFFFF9(-7), src2=2 -> res_data=0xFFFFFFFFFFFFFFFF (-1, sign-extended).
//  DIV src2=0 with DIV_BYPASS_EN -> res_valid at T+1, res_data=all ones, no div_valid.
//  DIV 0x8000000000000000 / -1 with DIV_BYPASS_EN -> res_data=0x8000000000000000.
//  flush 10 cycles into WAIT -> one div_flush pulse, no res_valid, in_ready next cycle.
//  res_ready low 5 cycles in DONE -> res_valid and res_data stay stable; TIMEOUT
//    with stuck divider -> timeout_err=1.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EXU-side requester that runs one DIV/DIVU/REM/REMU(W) op through the iterative divider.
// Define DIV_BYPASS_EN to resolve divide-by-zero and signed overflow locally without a divider run.
module div_issue_ctrl #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_flush,
    output logic            div_divw,
    output logic            div_signed,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    output logic            busy,
    output logic            timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    logic            op_rem;
    logic [CW-1:0]   wait_cnt;
    logic            accept;
    logic [XLEN-1:0] sel_res;
    logic [XLEN-1:0] fixed_res;
    logic            byp_hit;
    logic [XLEN-1:0] byp_res;

    assign accept    = in_valid && (state == IDLE) && !flush;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign div_valid = (state == REQ);
    assign res_valid = (state == DONE);

    // The divider zero-extends word results; RV64 wants them sign-extended from bit 31.
    always_comb begin
        sel_res   = op_rem ? div_remainder : div_quotient;
        fixed_res = div_divw ? {{(XLEN-32){sel_res[31]}}, sel_res[31:0]} : sel_res;
    end

`ifdef DIV_BYPASS_EN
    always_comb begin
        byp_hit = 1'b0;
        byp_res = '0;
        if (in_word) begin
            if (in_src2[31:0] == 32'd0) begin
                byp_hit = 1'b1;
                byp_res = in_op[1] ? {{(XLEN-32){in_src1[31]}}, in_src1[31:0]} : '1;
            end else if (!in_op[0] && in_src1[31:0] == 32'h8000_0000 && in_src2[31:0] == 32'hFFFF_FFFF) begin
                byp_hit = 1'b1;
                byp_res = in_op[1] ? '0 : {{(XLEN-32){1'b1}}, 32'h8000_0000};
            end
        end else begin
            if (in_src2 == '0) begin
                byp_hit = 1'b1;
                byp_res = in_op[1] ? in_src1 : '1;
            end else if (!in_op[0] && in_src1 == {1'b1, {(XLEN-1){1'b0}}} && in_src2 == '1) begin
                byp_hit = 1'b1;
                byp_res = in_op[1] ? '0 : in_src1;
            end
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_rem       <= 1'b0;
            wait_cnt     <= '0;
            div_divw     <= 1'b0;
            div_signed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            res_data     <= '0;
            div_flush    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            div_flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_rem       <= in_op[1];
                        div_divw     <= in_word;
                        div_signed   <= ~in_op[0];
                        div_dividend <= in_src1;
                        div_divisor  <= in_src2;
                        if (byp_hit) begin
                            res_data <= byp_res;
                            state    <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_ready) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // flush outranks a coincident result; the result outranks timeout
                    if (flush) begin
                        div_flush <= 1'b1;
                        state     <= IDLE;
                    end else if (div_out_valid) begin
                        res_data <= fixed_res;
                        state    <= DONE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        div_flush   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (flush || res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
